// File: rtl/truth_seq_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding
// and sizing constants used by the top level and the popcount helper.
package truth_seq_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Largest number of function inputs the sequencer is sized for
  localparam int MAX_N_VARS = 6;

  // Width of the settle-time down counter (SETTLE up to 15)
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/mask_popcount.sv
// Combinational popcount of a 2^N-bit minterm mask into an (N+1)-bit count.
// The count width covers the all-ones case (2^N needs N+1 bits).
module mask_popcount #(
  parameter int N = 3
) (
  input  logic [(1<<N)-1:0] i_vec,
  output logic [N:0]        o_count
);

  localparam int W = 1 << N;

  // Accumulate set bits across the whole mask
  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + (N+1)'(i_vec[i]);
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: steps an external N-input combinational block
// through every input combination, waits SETTLE cycles per row, samples
// its output and assembles the minterm mask plus its one-count.
// Optional build macro TRUTH_SEQ_ROW_HANDSHAKE_EN adds an i_row_ready
// input that holds each SAMPLE row until the consumer accepts it.
module truth_table_sequencer
  import truth_seq_pkg::*;
#(
  parameter int N_VARS = 3,
  parameter int SETTLE = 0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic [N_VARS-1:0]      o_vars,
  input  logic                   i_f_in,
`ifdef TRUTH_SEQ_ROW_HANDSHAKE_EN
  input  logic                   i_row_ready,
`endif
  output logic                   o_busy,
  output logic                   o_row_valid,
  output logic [N_VARS-1:0]      o_row_idx,
  output logic                   o_row_val,
  output logic                   o_done,
  output logic [(1<<N_VARS)-1:0] o_mask,
  output logic [N_VARS:0]        o_ones
);

  localparam int ROWS = 1 << N_VARS;
  localparam logic [N_VARS-1:0] LAST_IDX = '1;
  // Counter preload for a WAIT phase; unused when SETTLE is 0
  localparam int SETTLE_LOAD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_LOAD_I);

  state_t              r_state;
  logic [N_VARS-1:0]   r_idx;
  logic [N_VARS-1:0]   r_vars;
  logic [ROWS-1:0]     r_mask;
  logic [N_VARS:0]     r_ones;
  logic [SETTLE_W-1:0] r_cnt;
  logic                r_busy;
  logic                r_done;

  logic                w_advance;
  logic [ROWS-1:0]     w_mask_upd;
  logic [N_VARS:0]     w_count;

`ifdef TRUTH_SEQ_ROW_HANDSHAKE_EN
  assign w_advance = i_row_ready;
`else
  assign w_advance = 1'b1;
`endif

  // Mask as it will look once the current row is committed, so the final
  // one-count is available in the same cycle as the done pulse
  always_comb begin
    w_mask_upd        = r_mask;
    w_mask_upd[r_idx] = i_f_in;
  end

  mask_popcount #(
    .N (N_VARS)
  ) u_popcount (
    .i_vec   (w_mask_upd),
    .o_count (w_count)
  );

  // Sweep FSM with registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_vars  <= '0;
      r_mask  <= '0;
      r_ones  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mask <= '0;
            r_ones <= '0;
            r_idx  <= '0;
            r_vars <= '0;
            r_busy <= 1'b1;
            if (SETTLE > 0) begin
              r_state <= WAIT;
              r_cnt   <= SETTLE_LOAD;
            end else begin
              r_state <= SAMPLE;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt - SETTLE_W'(1);
          end
        end
        SAMPLE: begin
          // The row is committed only on its accepting cycle; stalled
          // cycles simply re-sample f_in
          if (w_advance) begin
            r_mask <= w_mask_upd;
            if (r_idx == LAST_IDX) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_ones  <= w_count;
            end else begin
              r_idx  <= r_idx + N_VARS'(1);
              r_vars <= r_idx + N_VARS'(1);
              if (SETTLE > 0) begin
                r_state <= WAIT;
                r_cnt   <= SETTLE_LOAD;
              end else begin
                r_state <= SAMPLE;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_vars      = r_vars;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mask      = r_mask;
  assign o_ones      = r_ones;
  assign o_row_idx   = r_idx;
  assign o_row_valid = (r_state == SAMPLE);
  assign o_row_val   = o_row_valid & i_f_in;

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Controller that exercises an external combinational N-input function block, such as a three-variable f(x,y,z) evaluator.
- Steps the block's inputs through every combination 0..2^N-1, waits a programmable settle time, and samples the block's output.
- Assembles the full truth table as a minterm mask and reports it with a one-count.
- Replaces hand-written per-row stimulus with a reusable, clocked sequencer on the function-evaluation datapath.

Parameters:
- N_VARS, 3: number of function inputs; legal range 1..6.
- SETTLE, 0: wait cycles between driving a combination and sampling f_in; legal range 0..15.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: reset, synchronous and active-high.
- start, input, 1: begin a sweep; sampled only in IDLE.
- vars, output, N_VARS: combination driven to the function block; bit N_VARS-1 = x (MSB).
- f_in, input, 1: function block output.
- busy, output, 1: high in every state except IDLE.
- row_valid, output, 1: high during SAMPLE.
- row_idx, output, N_VARS: index of the row currently sampled.
- row_val, output, 1: equals f_in during SAMPLE, 0 otherwise.
- done, output, 1: one-cycle pulse in DONE.
- mask, output, 2^N_VARS: bit i = f(i); held until the next accepted start.
- ones, output, N_VARS+1: popcount of mask; valid from DONE onward.

Behaviour:
- State machine: IDLE, WAIT, SAMPLE, DONE; all registers update on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - idx, vars, mask, ones, settle counter = 0.
  - busy, row_valid, row_val, done = 0.
- IDLE:
  - start=1: clear mask, idx=0, vars=0.
  - Then go to WAIT if SETTLE>0 (load counter=SETTLE-1), else go to SAMPLE.
  - start=0: stay in IDLE.
- WAIT: decrement counter; at 0 go to SAMPLE. vars holds idx throughout.
- SAMPLE:
  - mask[idx] <= f_in; row_valid=1 combinationally from state.
  - If idx == 2^N_VARS-1, go to DONE.
  - Otherwise idx++, vars = idx+1, and enter WAIT or SAMPLE per SETTLE.
- DONE:
  - done=1 for exactly one cycle; ones is registered here.
  - Unconditionally return to IDLE.
- Latency with SETTLE=0, N_VARS=3, start accepted at edge 0:
  - SAMPLE occupies cycles 1..8.
  - done is high in cycle 9.
  - busy falls in cycle 10.
- General sweep cost: (SETTLE+1)*2^N_VARS + 1 cycles from accept to done.
- start while busy: ignored, with no restart and no queuing.
- start in the DONE cycle: ignored; it is accepted only once back in IDLE.
- reset asserted mid-sweep: return to IDLE next edge; mask and ones are cleared and no done pulse is issued.
- idx wrap: idx never wraps. The terminal comparison stops the sweep, and vars is not incremented past 2^N_VARS-1.
- vars holds its last value in IDLE and DONE.

Optional Feature:
- Macro: TRUTH_SEQ_ROW_HANDSHAKE_EN.
- When defined:
  - Adds an input port row_ready (1 bit).
  - SAMPLE stays in SAMPLE, with row_valid held high and row_idx/row_val stable, until row_ready=1.
  - mask[idx] is written on the handshake cycle, so f_in is re-sampled every stall cycle and the last one wins.
  - reset overrides a pending stall.
- When undefined: no row_ready port exists and SAMPLE always lasts exactly one cycle.

Decomposition:
- Package truth_seq_pkg holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the maximum supported N_VARS constant (6);
  - the SETTLE counter width constant (4).
- One sub-module, mask_popcount: parameterised combinational popcount of a 2^N-bit vector to an (N+1)-bit count. It is instantiated once and registered into ones in DONE.

Test Plan:
- Basic sweep:
  - Setup: N_VARS=3, SETTLE=0, f_in driven by the model f = (x|~y)&(~y|~z); pulse start.
  - Expected: rows 0..7 report row_val = 1,1,0,0,1,1,1,0; done in cycle 9; mask=8'h73; ones=5.
- Settle timing:
  - Setup: SETTLE=2, same function.
  - Expected: each row has 2 WAIT cycles then 1 SAMPLE; done in cycle 25; mask=8'h73.
- Start while busy:
  - Setup: pulse start again at cycle 4 of a sweep.
  - Expected: sweep is unaffected; one done pulse only; mask=8'h73.
- Reset mid-sweep:
  - Setup: assert reset at cycle 5.
  - Expected: next cycle busy=0, mask=0, ones=0, vars=0, no done pulse.
  - Then a fresh start completes normally.
- Constant functions:
  - f_in tied 1 gives mask=8'hFF, ones=4'd8.
  - f_in tied 0 gives mask=8'h00, ones=0.
- Handshake (with TRUTH_SEQ_ROW_HANDSHAKE_EN defined):
  - Setup: hold row_ready=0 for 3 cycles on row 2.
  - Expected: row_valid stays high with row_idx=2 stable; done is delayed by exactly 3 cycles; mask=8'h73.
